// File: rtl/riscv_pkg.sv
// Shared riscv32 decode definitions: opcodes, immediate formats and a
// per-opcode control decode used by the front-end pipeline stages.
package riscv_pkg;

  localparam int REG_ADDR_W = 5;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  typedef enum logic [2:0] {
    FMT_R,
    FMT_I,
    FMT_S,
    FMT_B,
    FMT_U,
    FMT_J
  } imm_fmt_e;

  typedef struct packed {
    imm_fmt_e fmt;
    logic     uses_rs1;
    logic     uses_rs2;
    logic     has_rd;    // opcode writes rd (before the rd != 0 qualification)
    logic     illegal;
  } dec_ctrl_t;

  // Opcode-only control decode; unknown opcodes use no registers at all.
  function automatic dec_ctrl_t decode_ctrl(input logic [6:0] opcode);
    dec_ctrl_t c;
    c.fmt      = FMT_R;
    c.uses_rs1 = 1'b0;
    c.uses_rs2 = 1'b0;
    c.has_rd   = 1'b0;
    c.illegal  = 1'b0;
    case (opcode)
      OPC_LUI:    begin c.fmt = FMT_U; c.has_rd = 1'b1; end
      OPC_AUIPC:  begin c.fmt = FMT_U; c.has_rd = 1'b1; end
      OPC_JAL:    begin c.fmt = FMT_J; c.has_rd = 1'b1; end
      OPC_JALR:   begin c.fmt = FMT_I; c.uses_rs1 = 1'b1; c.has_rd = 1'b1; end
      OPC_BRANCH: begin c.fmt = FMT_B; c.uses_rs1 = 1'b1; c.uses_rs2 = 1'b1; end
      OPC_LOAD:   begin c.fmt = FMT_I; c.uses_rs1 = 1'b1; c.has_rd = 1'b1; end
      OPC_STORE:  begin c.fmt = FMT_S; c.uses_rs1 = 1'b1; c.uses_rs2 = 1'b1; end
      OPC_OP_IMM: begin c.fmt = FMT_I; c.uses_rs1 = 1'b1; c.has_rd = 1'b1; end
      OPC_OP:     begin
        c.fmt = FMT_R; c.uses_rs1 = 1'b1; c.uses_rs2 = 1'b1; c.has_rd = 1'b1;
      end
      default:    c.illegal = 1'b1;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/rv_imm_gen.sv
// Immediate generator: extracts and sign-extends the immediate of a
// riscv32 instruction for the given format. Purely combinational.
module rv_imm_gen
  import riscv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [31:0]      instr,
  input  imm_fmt_e         fmt,
  output logic [WIDTH-1:0] imm
);

  logic [31:0] imm32;

  // Assemble the 32-bit immediate; bit 31 of the instruction is always the sign.
  always_comb begin
    imm32 = '0;
    case (fmt)
      FMT_I: imm32 = {{20{instr[31]}}, instr[31:20]};
      FMT_S: imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      FMT_B: imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25],
                      instr[11:8], 1'b0};
      FMT_U: imm32 = {instr[31:12], 12'b0};
      FMT_J: imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20],
                      instr[30:21], 1'b0};
      default: imm32 = '0;
    endcase
  end

  assign imm = WIDTH'($signed(imm32));

endmodule

// File: rtl/operand_fetch.sv
// Decode / operand-fetch stage: decodes one instruction per cycle, reads
// the register file with writeback forwarding, stalls on RAW/WAW hazards
// via a busy scoreboard, and holds the result in a valid/ready register.
module operand_fetch
  import riscv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [31:0]           in_instr,
  input  logic [WIDTH-1:0]      in_pc,
  output logic [REG_ADDR_W-1:0] rf_read1_location,
  output logic [REG_ADDR_W-1:0] rf_read2_location,
  input  logic [WIDTH-1:0]      rf_read1_data,
  input  logic [WIDTH-1:0]      rf_read2_data,
  input  logic                  wb_valid,
  input  logic [REG_ADDR_W-1:0] wb_location,
  input  logic [WIDTH-1:0]      wb_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WIDTH-1:0]      out_pc,
  output logic [WIDTH-1:0]      out_rs1_data,
  output logic [WIDTH-1:0]      out_rs2_data,
  output logic [WIDTH-1:0]      out_imm,
  output logic [6:0]            out_opcode,
  output logic [2:0]            out_funct3,
  output logic [6:0]            out_funct7,
  output logic [REG_ADDR_W-1:0] out_rd,
  output logic                  out_writes_rd,
  output logic                  out_illegal
);

  logic [REG_ADDR_W-1:0] rs1;
  logic [REG_ADDR_W-1:0] rs2;
  logic [REG_ADDR_W-1:0] rd;
  logic [6:0]            opcode;
  dec_ctrl_t             ctrl;
  logic                  writes_rd;
  logic [WIDTH-1:0]      imm;
  logic [WIDTH-1:0]      rs1_val;
  logic [WIDTH-1:0]      rs2_val;
  logic [31:0]           busy;
  logic [31:0]           busy_next;
  logic                  wb_hits_rs1;
  logic                  wb_hits_rs2;
  logic                  wb_hits_rd;
  logic                  hazard;
  logic                  accept;

  assign opcode    = in_instr[6:0];
  assign rd        = in_instr[11:7];
  assign rs1       = in_instr[19:15];
  assign rs2       = in_instr[24:20];
  assign ctrl      = decode_ctrl(opcode);
  assign writes_rd = ctrl.has_rd && (rd != '0);

  assign rf_read1_location = rs1;
  assign rf_read2_location = rs2;

  rv_imm_gen #(.WIDTH(WIDTH)) u_imm_gen (
    .instr (in_instr),
    .fmt   (ctrl.fmt),
    .imm   (imm)
  );

  assign wb_hits_rs1 = wb_valid && (wb_location == rs1);
  assign wb_hits_rs2 = wb_valid && (wb_location == rs2);
  assign wb_hits_rd  = wb_valid && (wb_location == rd);

  // Operand select: x0 reads zero, then same-cycle writeback, then register file.
  always_comb begin
    rs1_val = rf_read1_data;
    rs2_val = rf_read2_data;
    if (rs1 == '0)       rs1_val = '0;
    else if (wb_hits_rs1) rs1_val = wb_data;
    if (rs2 == '0)       rs2_val = '0;
    else if (wb_hits_rs2) rs2_val = wb_data;
  end

  // A busy register being written back this cycle no longer blocks issue.
  always_comb begin
    hazard = 1'b0;
    if (ctrl.uses_rs1 && busy[rs1] && !wb_hits_rs1) hazard = 1'b1;
    if (ctrl.uses_rs2 && busy[rs2] && !wb_hits_rs2) hazard = 1'b1;
    if (writes_rd && busy[rd] && !wb_hits_rd)       hazard = 1'b1;
  end

  assign in_ready = !reset && (!out_valid || out_ready) && !hazard;
  assign accept   = in_valid && in_ready;

  // Scoreboard update: writeback clears, issue sets; set is applied last so it wins.
  always_comb begin
    busy_next = busy;
    if (wb_valid)             busy_next[wb_location] = 1'b0;
    if (accept && writes_rd)  busy_next[rd]          = 1'b1;
    busy_next[0] = 1'b0;
  end

  // Scoreboard register.
  always_ff @(posedge clk) begin
    if (reset) busy <= '0;
    else       busy <= busy_next;
  end

  // Output register: loads on accept, drops valid when consumed, otherwise holds.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid     <= 1'b0;
      out_pc        <= '0;
      out_rs1_data  <= '0;
      out_rs2_data  <= '0;
      out_imm       <= '0;
      out_opcode    <= '0;
      out_funct3    <= '0;
      out_funct7    <= '0;
      out_rd        <= '0;
      out_writes_rd <= 1'b0;
      out_illegal   <= 1'b0;
    end else if (accept) begin
      out_valid     <= 1'b1;
      out_pc        <= in_pc;
      out_rs1_data  <= rs1_val;
      out_rs2_data  <= rs2_val;
      out_imm       <= imm;
      out_opcode    <= opcode;
      out_funct3    <= in_instr[14:12];
      out_funct7    <= in_instr[31:25];
      out_rd        <= rd;
      out_writes_rd <= writes_rd;
      out_illegal   <= ctrl.illegal;
    end else if (out_valid && out_ready) begin
      out_valid     <= 1'b0;
    end
  end

endmodule

// File: tb/tb_operand_fetch.sv
// Directed bench for operand_fetch: hand-encoded instructions with
// hand-computed operands, immediates and stall behaviour.
module tb_operand_fetch;

  localparam int WIDTH = 32;

  logic             clk;
  logic             reset;
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_instr;
  logic [WIDTH-1:0] in_pc;
  logic [4:0]       rf_read1_location;
  logic [4:0]       rf_read2_location;
  logic [WIDTH-1:0] rf_read1_data;
  logic [WIDTH-1:0] rf_read2_data;
  logic             wb_valid;
  logic [4:0]       wb_location;
  logic [WIDTH-1:0] wb_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_pc;
  logic [WIDTH-1:0] out_rs1_data;
  logic [WIDTH-1:0] out_rs2_data;
  logic [WIDTH-1:0] out_imm;
  logic [6:0]       out_opcode;
  logic [2:0]       out_funct3;
  logic [6:0]       out_funct7;
  logic [4:0]       out_rd;
  logic             out_writes_rd;
  logic             out_illegal;

  int checks   = 0;
  int failures = 0;

  operand_fetch #(.WIDTH(WIDTH)) dut (
    .clk               (clk),
    .reset             (reset),
    .in_valid          (in_valid),
    .in_ready          (in_ready),
    .in_instr          (in_instr),
    .in_pc             (in_pc),
    .rf_read1_location (rf_read1_location),
    .rf_read2_location (rf_read2_location),
    .rf_read1_data     (rf_read1_data),
    .rf_read2_data     (rf_read2_data),
    .wb_valid          (wb_valid),
    .wb_location       (wb_location),
    .wb_data           (wb_data),
    .out_valid         (out_valid),
    .out_ready         (out_ready),
    .out_pc            (out_pc),
    .out_rs1_data      (out_rs1_data),
    .out_rs2_data      (out_rs2_data),
    .out_imm           (out_imm),
    .out_opcode        (out_opcode),
    .out_funct3        (out_funct3),
    .out_funct7        (out_funct7),
    .out_rd            (out_rd),
    .out_writes_rd     (out_writes_rd),
    .out_illegal       (out_illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic present(input logic [31:0] instr, input logic [31:0] pc);
    in_valid = 1'b1;
    in_instr = instr;
    in_pc    = pc;
  endtask

  initial begin
    reset         = 1'b1;
    in_valid      = 1'b0;
    in_instr      = '0;
    in_pc         = '0;
    rf_read1_data = 32'hDEADBEEF;
    rf_read2_data = 32'h12345678;
    wb_valid      = 1'b0;
    wb_location   = '0;
    wb_data       = '0;
    out_ready     = 1'b1;

    // Reset with a valid instruction waiting: nothing accepted.
    present(32'h00500093, 32'h100);
    tick(); tick();
    check_val("rst_in_ready", 32'(in_ready), 32'd0);
    check_val("rst_out_valid", 32'(out_valid), 32'd0);
    check_val("rst_out_pc", out_pc, 32'h0);
    check_val("rst_out_rd", 32'(out_rd), 32'd0);

    // ADDI x1,x0,5
    reset = 1'b0;
    #1;
    check_val("addi_in_ready", 32'(in_ready), 32'd1);
    check_val("addi_rf1_loc", 32'(rf_read1_location), 32'd0);
    tick();
    check_val("addi_out_valid", 32'(out_valid), 32'd1);
    check_val("addi_rd", 32'(out_rd), 32'd1);
    check_val("addi_imm", out_imm, 32'd5);
    check_val("addi_rs1_x0", out_rs1_data, 32'd0);
    check_val("addi_writes", 32'(out_writes_rd), 32'd1);
    check_val("addi_opcode", 32'(out_opcode), 32'h13);
    check_val("addi_pc", out_pc, 32'h100);

    // ADD x2,x1,x1 stalls on busy x1; the stalled output drains.
    present(32'h00108133, 32'h104);
    #1;
    check_val("add_raw_stall", 32'(in_ready), 32'd0);
    tick();
    check_val("add_drained", 32'(out_valid), 32'd0);

    // Writeback of x1 releases it in the same cycle through forwarding.
    wb_valid = 1'b1; wb_location = 5'd1; wb_data = 32'd5;
    #1;
    check_val("add_fwd_ready", 32'(in_ready), 32'd1);
    tick();
    wb_valid = 1'b0;
    check_val("add_valid", 32'(out_valid), 32'd1);
    check_val("add_rs1_fwd", out_rs1_data, 32'd5);
    check_val("add_rs2_fwd", out_rs2_data, 32'd5);
    check_val("add_rd", 32'(out_rd), 32'd2);
    check_val("add_imm_r", out_imm, 32'd0);
    check_val("add_opcode", 32'(out_opcode), 32'h33);

    // Backpressure: ADDI x3,x1,7 waits while execute is stalled.
    out_ready = 1'b0;
    rf_read1_data = 32'h11;
    present(32'h00708193, 32'h108);
    for (int i = 0; i < 3; i++) begin
      #1;
      check_val("bp_in_ready", 32'(in_ready), 32'd0);
      tick();
      check_val("bp_valid_hold", 32'(out_valid), 32'd1);
      check_val("bp_rd_hold", 32'(out_rd), 32'd2);
      check_val("bp_rs1_hold", out_rs1_data, 32'd5);
      check_val("bp_pc_hold", out_pc, 32'h104);
    end
    out_ready = 1'b1;
    #1;
    check_val("bp_release_ready", 32'(in_ready), 32'd1);
    tick();
    check_val("bp_next_rd", 32'(out_rd), 32'd3);
    check_val("bp_next_rs1", out_rs1_data, 32'h11);
    check_val("bp_next_imm", out_imm, 32'd7);
    check_val("bp_next_pc", out_pc, 32'h108);

    // ADDI x0,x0,1: x0 reads zero and writes nothing.
    rf_read1_data = 32'hDEADBEEF;
    present(32'h00100013, 32'h10C);
    #1;
    check_val("x0_ready", 32'(in_ready), 32'd1);
    tick();
    check_val("x0_rs1", out_rs1_data, 32'd0);
    check_val("x0_writes", 32'(out_writes_rd), 32'd0);
    check_val("x0_imm", out_imm, 32'd1);

    // SW x2,-4(x1): x2 is still busy until its writeback arrives.
    rf_read1_data = 32'h44;
    rf_read2_data = 32'h999;
    present(32'hFE20AE23, 32'h110);
    #1;
    check_val("sw_rs2_stall", 32'(in_ready), 32'd0);
    check_val("sw_rf2_loc", 32'(rf_read2_location), 32'd2);
    check_val("sw_rf1_loc", 32'(rf_read1_location), 32'd1);
    tick();
    wb_valid = 1'b1; wb_location = 5'd2; wb_data = 32'h22;
    #1;
    check_val("sw_fwd_ready", 32'(in_ready), 32'd1);
    tick();
    wb_valid = 1'b0;
    check_val("sw_imm", out_imm, 32'hFFFFFFFC);
    check_val("sw_writes", 32'(out_writes_rd), 32'd0);
    check_val("sw_rs1", out_rs1_data, 32'h44);
    check_val("sw_rs2_fwd", out_rs2_data, 32'h22);
    check_val("sw_funct3", 32'(out_funct3), 32'd2);
    check_val("sw_funct7", 32'(out_funct7), 32'h7F);

    // ADDI x5,x2,1: x2 has been cleared by its writeback.
    rf_read1_data = 32'h77;
    present(32'h00110293, 32'h114);
    #1;
    check_val("x2_free_ready", 32'(in_ready), 32'd1);
    tick();
    check_val("x2_free_rs1", out_rs1_data, 32'h77);
    check_val("x2_free_rd", 32'(out_rd), 32'd5);

    // Illegal opcode whose rs1 field names busy x3: no stall.
    present(32'h0001807F, 32'h118);
    #1;
    check_val("ill_ready", 32'(in_ready), 32'd1);
    tick();
    check_val("ill_flag", 32'(out_illegal), 32'd1);
    check_val("ill_writes", 32'(out_writes_rd), 32'd0);

    // Illegal opcode with rd=31 must not mark x31 busy.
    present(32'h00000FFF, 32'h11C);
    tick();
    check_val("ill2_flag", 32'(out_illegal), 32'd1);
    present(32'h000F8313, 32'h120);
    #1;
    check_val("x31_not_busy", 32'(in_ready), 32'd1);
    tick();
    check_val("x31_illegal", 32'(out_illegal), 32'd0);
    check_val("x31_rd", 32'(out_rd), 32'd6);

    // LUI x7,0xABCDE
    present(32'hABCDE3B7, 32'h124);
    tick();
    check_val("lui_imm", out_imm, 32'hABCDE000);
    check_val("lui_writes", 32'(out_writes_rd), 32'd1);
    check_val("lui_rd", 32'(out_rd), 32'd7);

    // BNE x0,x0,-8
    present(32'hFE001CE3, 32'h128);
    tick();
    check_val("bne_imm", out_imm, 32'hFFFFFFF8);
    check_val("bne_writes", 32'(out_writes_rd), 32'd0);
    check_val("bne_funct3", 32'(out_funct3), 32'd1);

    // JAL x0,+2048
    present(32'h0010006F, 32'h12C);
    tick();
    check_val("jal_imm", out_imm, 32'h00000800);
    check_val("jal_writes", 32'(out_writes_rd), 32'd0);

    // ADDI x3,x0,9: WAW on busy x3; writeback to idle x9 changes nothing.
    present(32'h00900193, 32'h130);
    wb_valid = 1'b1; wb_location = 5'd9; wb_data = 32'h55;
    #1;
    check_val("waw_stall", 32'(in_ready), 32'd0);
    tick();
    wb_valid = 1'b0;
    check_val("waw_drained", 32'(out_valid), 32'd0);
    #1;
    check_val("waw_still_stall", 32'(in_ready), 32'd0);

    // Reset while stalled clears the scoreboard.
    reset = 1'b1;
    #1;
    check_val("rst2_in_ready", 32'(in_ready), 32'd0);
    tick();
    reset = 1'b0;
    #1;
    check_val("rst2_out_valid", 32'(out_valid), 32'd0);
    check_val("rst2_out_imm", out_imm, 32'd0);
    check_val("rst2_busy_clear", 32'(in_ready), 32'd1);
    tick();
    check_val("post_rst_valid", 32'(out_valid), 32'd1);
    check_val("post_rst_imm", out_imm, 32'd9);
    check_val("post_rst_rd", 32'(out_rd), 32'd3);

    in_valid = 1'b0;
    tick();
    check_val("idle_valid", 32'(out_valid), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
